bcd_converter: RTL and testbench
================================

BCD_CONVERTER -- requirements
Module: bcd_converter

Interface
REQ-001 SHALL have parameter BIN_W, default 16: binary input width, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 5: number of output BCD digits, legal range 1..10.
REQ-003 SHALL have parameter SIGNED, default 0: 1 means binary_in is two's complement.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: conversion request, sampled on each rising edge.
REQ-007 SHALL have port binary_in, input, BIN_W bits: value sampled on the edge that accepts start.
REQ-008 SHALL have port bcd, output, 4*DIGITS bits: digit i is bcd[4i+3:4i], digit 0 is least significant.
REQ-009 SHALL have port blank, output, DIGITS bits: leading-zero blank mask, bit i covers digit i.
REQ-010 SHALL have port neg, output, 1 bit: result was negative (SIGNED=1 only, else tied 0).
REQ-011 SHALL have port ovf, output, 1 bit: magnitude exceeds 10^DIGITS-1.
REQ-012 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse marking results updated.

Function
REQ-014 SHALL use states IDLE, SHIFT and FINISH.
REQ-015 In IDLE with start=1, SHALL latch the magnitude of binary_in and the sign, load an iteration count of BIN_W, and go to SHIFT; busy SHALL be 1 from the next cycle.
REQ-016 In SHIFT, each cycle SHALL add 3 to every scratch digit that is >=5, then shift {scratch, operand} left by 1; after BIN_W shifts SHALL go to FINISH.
REQ-017 The scratch register SHALL hold INT_DIGITS = ((BIN_W*1233)>>12)+1 digits, so no carry is lost.
REQ-018 In FINISH, SHALL register bcd, blank, neg and ovf, pulse done=1 for one cycle with busy=0, and return to IDLE.
REQ-019 Latency SHALL be BIN_W+1 cycles from the start-accept edge to the edge that raises done.
REQ-020 If any scratch digit at or above DIGITS is nonzero, ovf SHALL be 1 and every bcd digit SHALL be 9.
REQ-021 With SIGNED=1, the magnitude SHALL be the two's-complement negation for negative inputs; -2^(BIN_W-1) SHALL convert exactly.
REQ-022 blank[i] SHALL be 1 when digit i and all higher digits are 0, except blank[0], which SHALL always be 0; when ovf=1, blank SHALL be all 0.
REQ-023 A start received while busy SHALL be stored in a one-deep pending register; a later start SHALL overwrite it (last wins).
REQ-024 In IDLE, if pending is valid and start=0, the pending value SHALL be converted as if start were asserted; if start=1 at the same time, the new value SHALL win and pending SHALL be cleared.
REQ-025 bcd, blank, neg and ovf SHALL hold their values until the next done pulse.

Reset
REQ-026 reset SHALL take priority over all other inputs, including mid-conversion.
REQ-027 On reset: state=IDLE, pending cleared, bcd=0, blank = all ones except bit 0, neg=0, ovf=0, busy=0, done=0.
REQ-028 A start asserted in the same cycle as reset SHALL be ignored.

Structure
REQ-029 Package bcd_pkg SHALL hold the state encoding, the INT_DIGITS calculation and the digit width constant (4).
REQ-030 The per-digit add-3 adjust SHALL be a sub-module bcd_digit_adj (4 bits in, 4 bits out), instantiated INT_DIGITS times by generate.

Verification
REQ-031 BIN_W=16, DIGITS=5: start with 754 -> done exactly 17 cycles after the accept edge; bcd digits 4..0 = 0,0,7,5,4; blank=11000; ovf=0.
REQ-032 BIN_W=16, DIGITS=4: input 65535 -> ovf=1, bcd=9999, blank=0000.
REQ-033 SIGNED=1, BIN_W=16, DIGITS=5: input 16'h8000 -> neg=1, bcd=32768; input 16'hFFFF -> neg=1, bcd=00001, blank=11110.
REQ-034 Start 754, then start 1234 at cycle 5, then start 9 at cycle 8 -> results 754 then 9; 1234 is never output; the second done arrives 2+17 cycles after the first.
REQ-035 Input 0 -> bcd=0, blank=11110; reset at cycle 6 of a conversion -> no done pulse, outputs at reset values, next start converts normally.

Source files
------------

// File: rtl/bcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bcd_pkg : shared state encoding and sizing for bcd_converter        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package bcd_pkg;

  localparam int c_DIGIT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // 1233/4096 approximates log10(2); one extra digit absorbs the rounding.
  function automatic int int_digits(input int bin_w);
    return ((bin_w * 1233) >>> 12) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bcd_digit_adj : double-dabble add-3 correction for one BCD digit    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [c_DIGIT_W-1:0] i_digit,
  output logic [c_DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= c_DIGIT_W'(5)) ? (i_digit + c_DIGIT_W'(3)) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bcd_converter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bcd_converter : sequential binary-to-BCD (double dabble) converter  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module bcd_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binary_in,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  neg,
  output logic                  ovf,
  output logic                  busy,
  output logic                  done
);

  localparam int c_INT_DIGITS = int_digits(BIN_W);
  localparam int c_SCR_W      = c_DIGIT_W * c_INT_DIGITS;
  localparam int c_EXT_DIGITS = (DIGITS > c_INT_DIGITS) ? DIGITS : c_INT_DIGITS;
  localparam int c_CNT_W      = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0]   c_BLANK_RST = ~DIGITS'(1);
  localparam logic [4*DIGITS-1:0] c_NINES     = {DIGITS{4'h9}};

  state_t                    r_state;
  logic [c_CNT_W-1:0]        r_cnt;
  logic [c_SCR_W-1:0]        r_scratch;
  logic [BIN_W-1:0]          r_operand;
  logic                      r_sign;
  logic                      r_pend_valid;
  logic [BIN_W-1:0]          r_pend_val;
  logic [4*DIGITS-1:0]       r_bcd;
  logic [DIGITS-1:0]         r_blank;
  logic                      r_neg;
  logic                      r_ovf;
  logic                      r_busy;
  logic                      r_done;

  logic [c_SCR_W-1:0]                  w_adj;
  logic                                w_launch;
  logic [BIN_W-1:0]                    w_src_val;
  logic                                w_src_neg;
  logic [BIN_W-1:0]                    w_src_mag;
  logic [c_DIGIT_W*c_EXT_DIGITS-1:0]   w_ext;
  logic                                w_ovf;
  logic [4*DIGITS-1:0]                 w_bcd;
  logic [DIGITS-1:0]                   w_blank;
  logic                                w_allz;

  for (genvar g = 0; g < c_INT_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_scratch[g*c_DIGIT_W +: c_DIGIT_W]),
      .o_digit (w_adj[g*c_DIGIT_W +: c_DIGIT_W])
    );
  end

  // Queued work waits out the done cycle so results are visible with the bus idle.
  assign w_launch  = start | (r_pend_valid & ~r_done);
  assign w_src_val = start ? binary_in : r_pend_val;
  assign w_src_neg = (SIGNED != 0) && w_src_val[BIN_W-1];
  assign w_src_mag = w_src_neg ? (~w_src_val + BIN_W'(1)) : w_src_val;

  always_comb begin
    w_ext = '0;
    w_ext[c_SCR_W-1:0] = r_scratch;
    w_ovf = 1'b0;
    for (int i = DIGITS; i < c_EXT_DIGITS; i++) begin
      w_ovf = w_ovf | (w_ext[i*c_DIGIT_W +: c_DIGIT_W] != 4'd0);
    end
    w_bcd   = w_ovf ? c_NINES : w_ext[4*DIGITS-1:0];
    w_blank = '0;
    w_allz  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_allz     = w_allz & (w_bcd[i*c_DIGIT_W +: c_DIGIT_W] == 4'd0);
      w_blank[i] = w_allz & ~w_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_scratch    <= '0;
      r_operand    <= '0;
      r_sign       <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_val   <= '0;
      r_bcd        <= '0;
      r_blank      <= c_BLANK_RST;
      r_neg        <= 1'b0;
      r_ovf        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != S_IDLE) && start) begin
        r_pend_valid <= 1'b1;
        r_pend_val   <= binary_in;
      end
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_scratch    <= '0;
            r_operand    <= w_src_mag;
            r_sign       <= w_src_neg;
            r_cnt        <= c_CNT_W'(BIN_W);
            r_pend_valid <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scratch <= {w_adj[c_SCR_W-2:0], r_operand[BIN_W-1]};
          r_operand <= {r_operand[BIN_W-2:0], 1'b0};
          r_cnt     <= r_cnt - c_CNT_W'(1);
          if (r_cnt == c_CNT_W'(1)) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_bcd   <= w_bcd;
          r_blank <= w_blank;
          r_neg   <= r_sign;
          r_ovf   <= w_ovf;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bcd   = r_bcd;
  assign blank = r_blank;
  assign neg   = r_neg;
  assign ovf   = r_ovf;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bcd_converter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bcd_converter : directed self-checking bench for bcd_converter   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_bcd_converter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] binary_in;

  logic [19:0] bcd0;  logic [4:0] blank0;  logic neg0, ovf0, busy0, done0;
  logic [15:0] bcd4;  logic [3:0] blank4;  logic neg4, ovf4, busy4, done4;
  logic [19:0] bcds;  logic [4:0] blanks;  logic negs, ovfs, busys, dones;

  int n_vec;
  int n_err;

  bcd_converter #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .binary_in(binary_in),
    .bcd(bcd0), .blank(blank0), .neg(neg0), .ovf(ovf0), .busy(busy0), .done(done0));

  bcd_converter #(.BIN_W(16), .DIGITS(4), .SIGNED(0)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .binary_in(binary_in),
    .bcd(bcd4), .blank(blank4), .neg(neg4), .ovf(ovf4), .busy(busy4), .done(done4));

  bcd_converter #(.BIN_W(16), .DIGITS(5), .SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .start(start), .binary_in(binary_in),
    .bcd(bcds), .blank(blanks), .neg(negs), .ovf(ovfs), .busy(busys), .done(dones));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept edge, then count edges until done (bounded).
  task automatic run_conv(input logic [15:0] val, output int lat);
    start = 1'b1;
    binary_in = val;
    tick();
    start = 1'b0;
    n_vec++;
    if (busy0 !== 1'b1) begin
      n_err++; $display("FAIL busy_after_accept: got %b want 1", busy0);
    end
    lat = 0;
    while (done0 !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; binary_in = 16'd1234;
    tick(); tick();
    n_vec++; if (bcd0 !== 20'h0) begin n_err++; $display("FAIL rst_bcd: got %h want 00000", bcd0); end
    n_vec++; if (blank0 !== 5'b11110) begin n_err++; $display("FAIL rst_blank: got %b want 11110", blank0); end
    n_vec++; if (blank4 !== 4'b1110) begin n_err++; $display("FAIL rst_blank4: got %b want 1110", blank4); end
    n_vec++; if ({neg0, ovf0, busy0, done0} !== 4'b0) begin
      n_err++; $display("FAIL rst_flags: got %b want 0000", {neg0, ovf0, busy0, done0});
    end
    reset = 1'b0; start = 1'b0;
    tick();
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL start_in_reset: busy got %b want 0", busy0); end
  endtask

  task automatic test_basic();
    int lat;
    run_conv(16'd754, lat);
    n_vec++; if (lat !== 17) begin n_err++; $display("FAIL latency_754: got %0d want 17", lat); end
    n_vec++; if (bcd0 !== 20'h00754) begin n_err++; $display("FAIL bcd_754: got %h want 00754", bcd0); end
    n_vec++; if (blank0 !== 5'b11000) begin n_err++; $display("FAIL blank_754: got %b want 11000", blank0); end
    n_vec++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL ovf_754: got %b want 0", ovf0); end
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL busy_at_done: got %b want 0", busy0); end
    n_vec++; if (bcds !== 20'h00754 || negs !== 1'b0) begin
      n_err++; $display("FAIL signed_754: got %h neg %b want 00754 neg 0", bcds, negs);
    end
    tick();
    n_vec++; if (done0 !== 1'b0) begin n_err++; $display("FAIL done_pulse: got %b want 0", done0); end
    tick(); tick();
    n_vec++; if (bcd0 !== 20'h00754) begin n_err++; $display("FAIL bcd_hold: got %h want 00754", bcd0); end
  endtask

  task automatic test_ovf();
    int lat;
    run_conv(16'hFFFF, lat);
    n_vec++; if (ovf4 !== 1'b1) begin n_err++; $display("FAIL ovf4_65535: got %b want 1", ovf4); end
    n_vec++; if (bcd4 !== 16'h9999) begin n_err++; $display("FAIL bcd4_65535: got %h want 9999", bcd4); end
    n_vec++; if (blank4 !== 4'b0000) begin n_err++; $display("FAIL blank4_65535: got %b want 0000", blank4); end
    n_vec++; if (bcd0 !== 20'h65535 || ovf0 !== 1'b0 || blank0 !== 5'b0) begin
      n_err++; $display("FAIL dut5_65535: got %h ovf %b blank %b want 65535 0 00000", bcd0, ovf0, blank0);
    end
    n_vec++; if (negs !== 1'b1 || bcds !== 20'h00001) begin
      n_err++; $display("FAIL signed_m1: got neg %b bcd %h want 1 00001", negs, bcds);
    end
    n_vec++; if (blanks !== 5'b11110) begin n_err++; $display("FAIL signed_m1_blank: got %b want 11110", blanks); end
  endtask

  task automatic test_signed_min();
    int lat;
    run_conv(16'h8000, lat);
    n_vec++; if (negs !== 1'b1 || bcds !== 20'h32768) begin
      n_err++; $display("FAIL signed_min: got neg %b bcd %h want 1 32768", negs, bcds);
    end
    n_vec++; if (neg0 !== 1'b0 || bcd0 !== 20'h32768) begin
      n_err++; $display("FAIL unsigned_32768: got neg %b bcd %h want 0 32768", neg0, bcd0);
    end
    n_vec++; if (ovf4 !== 1'b1 || bcd4 !== 16'h9999) begin
      n_err++; $display("FAIL ovf4_32768: got ovf %b bcd %h want 1 9999", ovf4, bcd4);
    end
  endtask

  task automatic test_zero();
    int lat;
    run_conv(16'd0, lat);
    n_vec++; if (bcd0 !== 20'h0 || blank0 !== 5'b11110) begin
      n_err++; $display("FAIL zero: got bcd %h blank %b want 00000 11110", bcd0, blank0);
    end
    n_vec++; if (ovf4 !== 1'b0 || blank4 !== 4'b1110) begin
      n_err++; $display("FAIL zero4: got ovf %b blank %b want 0 1110", ovf4, blank4);
    end
  endtask

  task automatic test_pending();
    int d1, d2, nd;
    logic [19:0] v1, v2;
    logic [4:0]  b2;
    d1 = -1; d2 = -1; nd = 0; v1 = '0; v2 = '0; b2 = '0;
    start = 1'b1; binary_in = 16'd754;
    tick();
    for (int e = 1; e <= 60; e++) begin
      start     = (e == 5) || (e == 8);
      binary_in = (e == 5) ? 16'd1234 : ((e == 8) ? 16'd9 : 16'd0);
      tick();
      start = 1'b0;
      if (done0 === 1'b1) begin
        nd++;
        if (nd == 1) begin d1 = e; v1 = bcd0; end
        if (nd == 2) begin d2 = e; v2 = bcd0; b2 = blank0; end
      end
    end
    n_vec++; if (nd !== 2) begin n_err++; $display("FAIL pend_count: got %0d dones want 2", nd); end
    n_vec++; if (d1 !== 17 || v1 !== 20'h00754) begin
      n_err++; $display("FAIL pend_first: got edge %0d bcd %h want 17 00754", d1, v1);
    end
    n_vec++; if ((d2 - d1) !== 19) begin n_err++; $display("FAIL pend_gap: got %0d want 19", d2 - d1); end
    n_vec++; if (v2 !== 20'h00009 || b2 !== 5'b11110) begin
      n_err++; $display("FAIL pend_last_wins: got %h blank %b want 00009 11110", v2, b2);
    end
  endtask

  task automatic test_reset_mid();
    int nd, lat;
    nd = 0;
    start = 1'b1; binary_in = 16'd1234;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (done0 === 1'b1) nd++;
    end
    n_vec++; if (nd !== 0) begin n_err++; $display("FAIL mid_reset_done: got %0d pulses want 0", nd); end
    n_vec++; if (bcd0 !== 20'h0 || blank0 !== 5'b11110 || busy0 !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_outs: got %h %b busy %b want 00000 11110 0", bcd0, blank0, busy0);
    end
    run_conv(16'd4321, lat);
    n_vec++; if (lat !== 17 || bcd0 !== 20'h04321 || blank0 !== 5'b10000) begin
      n_err++; $display("FAIL after_reset: got lat %0d bcd %h blank %b want 17 04321 10000", lat, bcd0, blank0);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; binary_in = '0;
    test_reset();
    test_basic();
    test_ovf();
    test_signed_min();
    test_zero();
    test_pending();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
